// File: rtl/fetch_redirect_sched_pkg.sv
// Shared types for the fetch redirect scheduler: address type, FSM state
// encoding and the width of the interrupt source index.
package fetch_redirect_sched_pkg;

  typedef logic [31:0] address_t;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_WAIT,
    FS_DISPATCH,
    FS_BLACKOUT
  } fetch_sched_state_e;

  localparam int INT_ID_W  = 4;
  localparam int BLK_CNT_W = 4;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational fixed-priority encoder: reports whether any request is set
// and the lowest set index.
module prio_enc_lsb
  import fetch_redirect_sched_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]          req,
  output logic                  valid,
  output logic [INT_ID_W-1:0]   idx
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = INT_ID_W'(i);
    end
  end

endmodule

// File: rtl/fetch_redirect_sched.sv
// Fetch redirection scheduler: arbitrates branch redirects, interrupt
// dispatch and the fetch wait state; every output is registered.
module fetch_redirect_sched
  import fetch_redirect_sched_pkg::*;
#(
  parameter int       N_INT          = 8,
  parameter address_t VECT_BASE      = 32'h0000_0100,
  parameter int       VECT_STRIDE_LG = 5,
  parameter int       BLACKOUT       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 branch_jump,
  input  logic [31:0]          branch_target,
  input  logic                 wait_req,
  input  logic                 int_enable,
  input  logic [N_INT-1:0]     int_mask,
  input  logic [N_INT-1:0]     int_req,
  output logic [31:0]          new_pc,
  output logic                 jump,
  output logic [31:0]          int_vect,
  output logic                 int_jump,
  output logic                 if_wait,
  output logic                 int_taken,
  output logic [INT_ID_W-1:0]  int_id
);

  fetch_sched_state_e   state, state_nxt;
  logic [BLK_CNT_W-1:0] blk_cnt, blk_nxt;
  logic [N_INT-1:0]     armed, pend;
  logic                 pend_vld;
  logic [INT_ID_W-1:0]  sel;
  logic                 take_branch, load_vect, taken_nxt;

  function automatic address_t vect_addr(input logic [INT_ID_W-1:0] id);
    address_t off;
    off = address_t'(id) << VECT_STRIDE_LG;
    return VECT_BASE + off;
  endfunction

  // The wait state wakes on masked requests even with interrupts disabled.
  assign armed = int_req & int_mask;
  assign pend  = armed & {N_INT{int_enable}};

  prio_enc_lsb #(.N(N_INT)) u_prio_enc (
    .req   (pend),
    .valid (pend_vld),
    .idx   (sel)
  );

  always_comb begin
    state_nxt   = state;
    blk_nxt     = blk_cnt;
    take_branch = 1'b0;
    load_vect   = 1'b0;
    taken_nxt   = 1'b0;
    case (state)
      FS_RUN: begin
        if (!hold) begin
          if (branch_jump) begin
            take_branch = 1'b1;
          end else if (pend_vld) begin
            state_nxt = FS_DISPATCH;
            load_vect = 1'b1;
          end else if (wait_req) begin
            state_nxt = FS_WAIT;
          end
        end
      end
      FS_WAIT: begin
        if (|armed) begin
          if (int_enable) begin
            state_nxt = FS_DISPATCH;
            load_vect = 1'b1;
          end else begin
            state_nxt = FS_RUN;
          end
        end
      end
      FS_DISPATCH: begin
        if (!hold) begin
          taken_nxt = 1'b1;
          state_nxt = FS_BLACKOUT;
          blk_nxt   = BLK_CNT_W'(BLACKOUT - 1);
        end
      end
      FS_BLACKOUT: begin
        // Branches are still served; the counter ignores hold.
        take_branch = branch_jump & ~hold;
        if (blk_cnt == '0) begin
          state_nxt = FS_RUN;
        end else begin
          blk_nxt = blk_cnt - BLK_CNT_W'(1);
        end
      end
      default: state_nxt = FS_RUN;
    endcase
  end

  // Registered stage: state, counter and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FS_RUN;
      blk_cnt   <= '0;
      jump      <= 1'b0;
      new_pc    <= '0;
      int_jump  <= 1'b0;
      int_vect  <= '0;
      int_id    <= '0;
      if_wait   <= 1'b0;
      int_taken <= 1'b0;
    end else begin
      state     <= state_nxt;
      blk_cnt   <= blk_nxt;
      jump      <= take_branch;
      int_jump  <= (state_nxt == FS_DISPATCH);
      if_wait   <= (state_nxt == FS_WAIT);
      int_taken <= taken_nxt;
      if (take_branch) new_pc <= branch_target;
      if (load_vect) begin
        int_vect <= vect_addr(sel);
        int_id   <= sel;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_sched.sv
// Randomised bench for fetch_redirect_sched with a behavioural reference
// model, plus directed scenarios pinned by hand-computed values.
module tb_fetch_redirect_sched;

  localparam int          BLACKOUT  = 4;
  localparam logic [31:0] VECT_BASE = 32'h0000_0100;
  localparam int          STRIDE    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        branch_jump = 1'b0;
  logic [31:0] branch_target = '0;
  logic        wait_req = 1'b0;
  logic        int_enable = 1'b0;
  logic [7:0]  int_mask = '0;
  logic [7:0]  int_req = '0;
  logic [31:0] new_pc, int_vect;
  logic        jump, int_jump, if_wait, int_taken;
  logic [3:0]  int_id;

  fetch_redirect_sched dut (
    .clk(clk), .reset(reset), .hold(hold), .branch_jump(branch_jump),
    .branch_target(branch_target), .wait_req(wait_req), .int_enable(int_enable),
    .int_mask(int_mask), .int_req(int_req), .new_pc(new_pc), .jump(jump),
    .int_vect(int_vect), .int_jump(int_jump), .if_wait(if_wait),
    .int_taken(int_taken), .int_id(int_id)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 0;

  // Reference model: expected outputs plus a coarse view of what the
  // scheduler is doing (waiting, dispatching, blackout cycles left).
  logic [31:0] m_new_pc = '0, m_int_vect = '0;
  logic        m_jump = 0, m_int_jump = 0, m_if_wait = 0, m_int_taken = 0;
  logic [3:0]  m_int_id = '0;
  bit          m_in_wait = 0, m_disp = 0;
  int          m_blk_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic start_dispatch(input int s);
    m_disp     = 1;
    m_int_jump = 1;
    m_int_vect = VECT_BASE + 32'(s * STRIDE);
    m_int_id   = 4'(s);
  endtask

  task automatic model_update();
    logic [7:0] armed;
    int s;
    armed = int_req & int_mask;
    s = lowest(int_enable ? armed : 8'h00);
    m_jump = 0;
    m_int_taken = 0;
    if (reset) begin
      m_new_pc = '0; m_int_vect = '0; m_int_jump = 0; m_if_wait = 0; m_int_id = '0;
      m_in_wait = 0; m_disp = 0; m_blk_left = 0;
    end else if (m_disp) begin
      if (!hold) begin
        m_disp = 0; m_int_jump = 0; m_int_taken = 1; m_blk_left = BLACKOUT;
      end
    end else if (m_in_wait) begin
      if (armed != 0) begin
        m_in_wait = 0; m_if_wait = 0;
        if (int_enable) start_dispatch(s);
      end
    end else if (m_blk_left > 0) begin
      m_blk_left--;
      if (branch_jump && !hold) begin m_jump = 1; m_new_pc = branch_target; end
    end else if (!hold) begin
      if (branch_jump) begin m_jump = 1; m_new_pc = branch_target; end
      else if (s >= 0) start_dispatch(s);
      else if (wait_req) begin m_in_wait = 1; m_if_wait = 1; end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    chk("rst_outs_zero", 32'(jump | int_jump | if_wait | int_taken | (|new_pc) | (|int_vect) | (|int_id)), 32'd0);
    cyc();
    reset = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("jump", 32'(jump), 32'(m_jump));
      chk("new_pc", new_pc, m_new_pc);
      chk("int_jump", 32'(int_jump), 32'(m_int_jump));
      chk("int_vect", int_vect, m_int_vect);
      chk("if_wait", 32'(if_wait), 32'(m_if_wait));
      chk("int_taken", 32'(int_taken), 32'(m_int_taken));
      chk("int_id", 32'(int_id), 32'(m_int_id));
      chk("strobe_excl", 32'(jump & int_jump), 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int gap, pulses;
    // Scenario 1: requests pending throughout reset
    int_req = 8'hFF; int_mask = 8'hFF; int_enable = 1;
    cyc();
    chk_en = 1;
    do_reset();
    cyc();
    chk("t1_int_jump", 32'(int_jump), 32'd1);
    chk("t1_int_vect", int_vect, 32'h100);
    chk("t1_int_id", 32'(int_id), 32'd0);

    // Scenario 2: lowest source wins, then blackout spacing
    int_req = 8'b0000_1100;
    do_reset();
    cyc();
    chk("t2_int_vect", int_vect, 32'h140);
    chk("t2_int_id", 32'(int_id), 32'd2);
    cyc();
    chk("t2_int_taken", 32'(int_taken), 32'd1);
    gap = 1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (int_jump) break;
      gap++;
    end
    chk("t2_redispatch_gap", 32'(gap), 32'd5);

    // Scenario 3: branch beats interrupt in the same cycle
    int_req = 8'h00;
    do_reset();
    cyc();
    branch_jump = 1; branch_target = 32'h2000; int_req = 8'h01;
    cyc();
    chk("t3_jump", 32'(jump), 32'd1);
    chk("t3_new_pc", new_pc, 32'h2000);
    chk("t3_no_int_jump", 32'(int_jump), 32'd0);
    branch_jump = 0;
    cyc();
    chk("t3_int_jump_next", 32'(int_jump), 32'd1);
    chk("t3_new_pc_held", new_pc, 32'h2000);

    // Scenario 4: dispatch stretched by hold
    do_reset();
    cyc();
    int_req = 8'h00; hold = 1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_hold_int_jump", 32'(int_jump), 32'd1);
      pulses += int'(int_taken);
    end
    hold = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      pulses += int'(int_taken);
    end
    chk("t4_taken_pulses", 32'(pulses), 32'd1);

    // Scenario 5: wait state, woken with and without enable
    int_enable = 0;
    do_reset();
    wait_req = 1;
    cyc();
    chk("t5_if_wait", 32'(if_wait), 32'd1);
    wait_req = 0; int_req = 8'h20;
    cyc();
    chk("t5_wake_if_wait", 32'(if_wait), 32'd0);
    chk("t5_wake_no_int", 32'(int_jump), 32'd0);
    cyc();
    chk("t5_run_no_int", 32'(int_jump), 32'd0);
    int_req = 8'h00; wait_req = 1; int_enable = 1;
    cyc();
    wait_req = 0; int_req = 8'h20;
    cyc();
    chk("t5_en_int_jump", 32'(int_jump), 32'd1);
    chk("t5_en_int_vect", int_vect, 32'h1A0);
    chk("t5_en_if_wait", 32'(if_wait), 32'd0);

    // Scenario 6: reset during blackout and during wait
    int_req = 8'h01;
    do_reset();
    cyc();
    cyc();
    int_req = 8'h00; reset = 1;
    cyc();
    chk("t6_blk_reset", 32'(jump | int_jump | if_wait | int_taken | (|new_pc) | (|int_vect) | (|int_id)), 32'd0);
    reset = 0; wait_req = 1;
    cyc();
    chk("t6_wait_entered", 32'(if_wait), 32'd1);
    wait_req = 0; reset = 1;
    cyc();
    chk("t6_wait_reset", 32'(jump | int_jump | if_wait | int_taken | (|new_pc) | (|int_vect) | (|int_id)), 32'd0);
    reset = 0;
    cyc();
    chk("t6_idle_after", 32'(if_wait | int_jump), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      hold          = ($urandom_range(0, 3) == 0);
      branch_jump   = ($urandom_range(0, 4) == 0);
      branch_target = $urandom;
      wait_req      = ($urandom_range(0, 7) == 0);
      int_enable    = ($urandom_range(0, 3) != 0);
      int_mask      = 8'($urandom);
      int_req       = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      cyc();
    end
    reset = 1;
    cyc();
    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
